// File: rtl/sample_interpolator.sv
// Buffers input samples in a 2-entry FIFO and emits 2^L linearly interpolated
// points per sample, one per advance pulse; flags underrun when a segment starts dry.
module sample_interpolator #(
  parameter int IN_BITS         = 16,
  parameter int MAX_INTERP_LOG2 = 4,
  parameter int L_BITS          = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] in_data,
  input  logic [L_BITS-1:0]  interp_log2,
  input  logic               advance,
  output logic [IN_BITS-1:0] u,
  output logic               underrun,
  input  logic               clear_underrun
);

  localparam int PH_BITS  = MAX_INTERP_LOG2;
  localparam int ACC_BITS = IN_BITS + MAX_INTERP_LOG2 + 1;
  localparam logic [L_BITS-1:0] L_MAX = L_BITS'(MAX_INTERP_LOG2);

  logic [IN_BITS-1:0]  fifo_mem [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;
  logic                full, empty, push, pop;

  logic [IN_BITS-1:0]  p0, p1;
  logic [ACC_BITS-1:0] acc;
  logic [PH_BITS-1:0]  phase;
  logic [L_BITS-1:0]   l_cur;

  logic [IN_BITS:0]    delta;
  logic [ACC_BITS-1:0] delta_ext, acc_step, acc_end;
  logic [PH_BITS-1:0]  last_phase;
  logic [L_BITS-1:0]   shamt, l_next;
  logic                wrap;
  logic                unused_acc_msb;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign in_ready = reset_n && !full;
  assign push     = in_valid && in_ready;

  assign last_phase = ~({PH_BITS{1'b1}} << l_cur);
  assign wrap       = (phase == last_phase);
  assign pop        = advance && wrap && !empty;

  assign delta     = {p1[IN_BITS-1], p1} - {p0[IN_BITS-1], p0};
  assign delta_ext = {{PH_BITS{delta[IN_BITS]}}, delta};
  assign shamt     = L_MAX - l_cur;
  assign acc_step  = delta_ext << shamt;
  assign acc_end   = {p1[IN_BITS-1], p1, {PH_BITS{1'b0}}};
  assign l_next    = (interp_log2 > L_MAX) ? L_MAX : interp_log2;

  // acc never leaves the p0..p1 range, so u is a plain floor slice
  assign u              = acc[IN_BITS+PH_BITS-1:PH_BITS];
  assign unused_acc_msb = acc[ACC_BITS-1];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      p0       <= '0;
      p1       <= '0;
      acc      <= '0;
      phase    <= '0;
      l_cur    <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (clear_underrun) underrun <= 1'b0;

      if (advance) begin
        if (wrap) begin
          // land exactly on the endpoint so rounding error never accumulates
          acc   <= acc_end;
          p0    <= p1;
          phase <= '0;
          l_cur <= l_next;
          if (!empty) p1 <= fifo_mem[rd_ptr];
          else        underrun <= 1'b1;
        end else begin
          acc   <= acc + acc_step;
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_interpolator.sv
// Scoreboard bench for sample_interpolator: a behavioural model predicts u per advance,
// the FIFO handshake and the sticky underrun flag.
module tb_sample_interpolator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  interp_log2;
  logic        advance;
  logic [15:0] u;
  logic        underrun;
  logic        clear_underrun;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_q[$];
  int fifo_q[$];
  int m_p0, m_p1, m_j, m_l;
  bit m_und;

  sample_interpolator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .interp_log2    (interp_log2),
    .advance        (advance),
    .u              (u),
    .underrun       (underrun),
    .clear_underrun (clear_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_p0 = 0; m_p1 = 0; m_j = 0; m_l = 0; m_und = 0;
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      reset_n = 1'b0; in_valid = 1'b1; in_data = 16'd77;
      advance = 1'b1; clear_underrun = 1'b0; interp_log2 = 3'd2;
      #1 check("rst_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      check("rst_u", int'($signed(u)), 0);
      check("rst_underrun", int'(underrun), 0);
    end
    model_reset();
    reset_n = 1'b1; in_valid = 1'b0; advance = 1'b0;
    #1 check("rel_in_ready", int'(in_ready), 1);
  endtask

  task automatic step(input bit v, input int d, input bit adv, input bit clr, input int il);
    bit exp_ready, accept, und_set;
    int expu;
    in_valid = v; in_data = 16'(d); advance = adv;
    clear_underrun = clr; interp_log2 = 3'(il);
    #1;
    exp_ready = (fifo_q.size() < 2);
    check("in_ready", int'(in_ready), int'(exp_ready));
    accept = v && exp_ready;
    und_set = 1'b0;
    if (adv) begin
      if (m_j == (1 << m_l) - 1) begin
        expu = m_p1;
        m_p0 = m_p1;
        m_j  = 0;
        m_l  = (il > 4) ? 4 : il;
        if (fifo_q.size() > 0) m_p1 = fifo_q.pop_front();
        else                   und_set = 1'b1;
      end else begin
        m_j++;
        expu = m_p0 + (((m_p1 - m_p0) * m_j) >>> m_l);
      end
      exp_q.push_back(expu);
    end
    if (clr)     m_und = 1'b0;
    if (und_set) m_und = 1'b1;
    if (accept)  fifo_q.push_back(d);
    @(posedge clk); #1;
    if (adv) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else                   check("u", int'($signed(u)), exp_q.pop_front());
    end
    check("underrun", int'(underrun), int'(m_und));
  endtask

  task automatic adv_n(input int n, input int il);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0, il);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; advance = 1'b0;
    clear_underrun = 1'b0; interp_log2 = '0;
    model_reset();

    rst_cycles(3);

    // first wrap runs dry and latches L=2; then ramp 0 -> 400
    step(1'b0, 0, 1'b1, 1'b0, 2);
    step(1'b1, 400, 1'b0, 1'b0, 2);
    adv_n(8, 2);
    step(1'b0, 0, 1'b0, 1'b1, 2);

    // dry wrap holds 400; clear alone, then clear racing a set
    adv_n(4, 2);
    step(1'b0, 0, 1'b0, 1'b1, 2);
    adv_n(3, 2);
    step(1'b0, 0, 1'b1, 1'b1, 2);
    step(1'b0, 0, 1'b0, 1'b1, 2);

    // descending segment 400 -> -400
    step(1'b1, -400, 1'b0, 1'b0, 2);
    adv_n(8, 2);

    // fill the FIFO, third push waits until a pop frees a slot
    step(1'b1, 0, 1'b0, 1'b0, 2);
    step(1'b1, 1, 1'b0, 1'b0, 2);
    step(1'b1, 5, 1'b0, 1'b0, 2);
    step(1'b1, 5, 1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b1, 1'b0, 2);
    step(1'b1, 5, 1'b0, 1'b0, 2);
    step(1'b1, -3, 1'b0, 1'b0, 2);
    adv_n(16, 2);

    // interp_log2 change mid-segment only takes effect at the next wrap
    step(1'b1, -1000, 1'b0, 1'b0, 2);
    step(1'b1, 3000, 1'b0, 1'b0, 2);
    adv_n(2, 2);
    adv_n(40, 7);

    // L=0: every advance is a wrap
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 7 : -7, 1'b1, 1'b0, 0);
    adv_n(4, 0);
    step(1'b0, 0, 1'b0, 1'b1, 0);

    // reset mid-segment drops FIFO contents
    step(1'b1, 123, 1'b0, 1'b0, 3);
    step(1'b1, 321, 1'b1, 1'b0, 3);
    adv_n(3, 3);
    rst_cycles(2);
    adv_n(3, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
